// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the fetch unit / pipelined datapath and the
// pipelined controller.
//   master : fetch side, drives ins_valid/ins, consumes all control outputs
//   slave  : pipe_ctrl, consumes the IF/ID instruction, drives control
// Signals:
//   ins_valid, ins[31:0]        fetched instruction from the IF/ID register
//   ins_ready                   decode accepts ins (low = hold PC and IF/ID)
//   ex_valid, ex_alu_sel, ex_alu_code, jr_taken   EX-stage control
//   mem_wen, mem_valid          MEM-stage control
//   wb_reg_wen, wb_dmem_alu, wb_reg_addr          WB-stage control
//   stall_cnt                   saturating load-use stall counter
interface pipe_ctrl_if #(
    parameter int ALU_CODE_W = 5,
    parameter int CNT_W      = 16
);
    logic                  ins_valid;
    logic [31:0]           ins;
    logic                  ins_ready;
    logic                  ex_valid;
    logic                  ex_alu_sel;
    logic [ALU_CODE_W-1:0] ex_alu_code;
    logic                  jr_taken;
    logic                  mem_wen;
    logic                  mem_valid;
    logic                  wb_reg_wen;
    logic                  wb_dmem_alu;
    logic [4:0]            wb_reg_addr;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output ins_valid, ins,
        input  ins_ready, ex_valid, ex_alu_sel, ex_alu_code, jr_taken,
               mem_wen, mem_valid, wb_reg_wen, wb_dmem_alu, wb_reg_addr,
               stall_cnt
    );

    modport slave (
        input  ins_valid, ins,
        output ins_ready, ex_valid, ex_alu_sel, ex_alu_code, jr_taken,
               mem_wen, mem_valid, wb_reg_wen, wb_dmem_alu, wb_reg_addr,
               stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined MIPS controller. Decodes the IF/ID instruction and
// carries its control through registered EX, MEM and WB stages. Detects
// load-use hazards (one-cycle fetch hold plus bubble into EX) and squashes
// the instruction accepted while a valid jr sits in EX.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (drops all in-flight instructions)
//   bus   pipe_ctrl_if.slave (instruction in, stage control out)
// Parameters:
//   ALU_CODE_W  width of ALU code fields, must be >= 5
//   CNT_W       width of the stall counter
// Build option:
//   PIPE_CTRL_DELAY_SLOT_EN  branch-delay-slot semantics: the instruction
//   after jr executes normally and the flush logic is compiled out.
module pipe_ctrl #(
    parameter int ALU_CODE_W = 5,
    parameter int CNT_W      = 16
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    typedef struct packed {
        logic       reg_wen;
        logic       dmem_alu;
        logic [4:0] reg_addr;
    } wb_t;

    typedef struct packed {
        logic mem_wen;
        wb_t  wb;
    } mem_t;

    // alu_code is the MSB field so the bubble constant below stays simple
    typedef struct packed {
        logic [ALU_CODE_W-1:0] alu_code;
        logic                  alu_sel;
        logic                  is_lw;
        logic                  is_jr;
        mem_t                  mem;
    } ex_t;

    localparam ex_t EX_BUBBLE =
        ex_t'({ALU_CODE_W'(12), {($bits(ex_t) - ALU_CODE_W){1'b0}}});

    function automatic logic [ALU_CODE_W-1:0] ac(input int c);
        return ALU_CODE_W'(c);
    endfunction

    ex_t              ex_q;
    mem_t             mem_q;
    wb_t              wb_q;
    logic [2:1]       vld_pipe;     // [1] = EX valid, [2] = MEM valid
    logic [CNT_W-1:0] stall_cnt_q;

    // ---------------- decode ----------------
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    ex_t        dec;
    logic       dec_ok, use_rs, use_rt;

    assign opcode = bus.ins[31:26];
    assign rs     = bus.ins[25:21];
    assign rt     = bus.ins[20:16];
    assign rd     = bus.ins[15:11];
    assign funct  = bus.ins[5:0];

    always_comb begin
        dec    = EX_BUBBLE;
        dec_ok = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        if (bus.ins != 32'h0) begin
            if (opcode == 6'h00) begin
                dec_ok              = 1'b1;
                dec.mem.wb.reg_wen  = 1'b1;
                dec.mem.wb.reg_addr = rd;
                use_rs              = 1'b1;
                use_rt              = 1'b1;
                case (funct)
                    6'h20: dec.alu_code = ac(0);
                    6'h21: dec.alu_code = ac(1);
                    6'h22: dec.alu_code = ac(2);
                    6'h23: dec.alu_code = ac(3);
                    6'h24: dec.alu_code = ac(4);
                    6'h25: dec.alu_code = ac(5);
                    6'h27: dec.alu_code = ac(6);
                    6'h2A: dec.alu_code = ac(7);
                    // shifts take their amount from shamt, so rs is not read
                    6'h00: begin dec.alu_code = ac(8);  use_rs = 1'b0; end
                    6'h02: begin dec.alu_code = ac(9);  use_rs = 1'b0; end
                    6'h03: begin dec.alu_code = ac(10); use_rs = 1'b0; end
                    6'h08: begin
                        dec.alu_code       = ac(11);
                        dec.is_jr          = 1'b1;
                        dec.mem.wb.reg_wen = 1'b0;
                        use_rt             = 1'b0;
                    end
                    default: begin
                        dec    = EX_BUBBLE;
                        dec_ok = 1'b0;
                        use_rs = 1'b0;
                        use_rt = 1'b0;
                    end
                endcase
            end else begin
                dec_ok              = 1'b1;
                dec.alu_sel         = 1'b1;
                dec.mem.wb.reg_wen  = 1'b1;
                dec.mem.wb.reg_addr = rt;
                use_rs              = 1'b1;
                case (opcode)
                    6'h0C: dec.alu_code = ac(13);
                    6'h0D: dec.alu_code = ac(14);
                    6'h0A: dec.alu_code = ac(15);
                    6'h08: dec.alu_code = ac(16);
                    6'h09: dec.alu_code = ac(17);
                    6'h0F: begin dec.alu_code = ac(20); use_rs = 1'b0; end
                    6'h23: begin
                        dec.alu_code        = ac(18);
                        dec.is_lw           = 1'b1;
                        dec.mem.wb.dmem_alu = 1'b1;
                    end
                    6'h2B: begin
                        dec.alu_code       = ac(19);
                        dec.mem.mem_wen    = 1'b1;
                        dec.mem.wb.reg_wen = 1'b0;
                        use_rt             = 1'b1;
                    end
                    default: begin
                        dec    = EX_BUBBLE;
                        dec_ok = 1'b0;
                        use_rs = 1'b0;
                    end
                endcase
            end
            // $0 is hardwired; never request a write to it
            if (dec.mem.wb.reg_addr == 5'd0)
                dec.mem.wb.reg_wen = 1'b0;
        end
    end

    // ---------------- hazard / flush ----------------
    logic ex_lw_hit, hazard, jr_taken, take;

    // lw in EX always carries its rt in reg_addr
    assign ex_lw_hit = vld_pipe[1] && ex_q.is_lw && (ex_q.mem.wb.reg_addr != 5'd0);
    assign hazard    = bus.ins_valid && ex_lw_hit &&
                       ((use_rs && (rs == ex_q.mem.wb.reg_addr)) ||
                        (use_rt && (rt == ex_q.mem.wb.reg_addr)));
    assign jr_taken  = vld_pipe[1] && ex_q.is_jr;

`ifdef PIPE_CTRL_DELAY_SLOT_EN
    assign bus.ins_ready = rst || !hazard;
    assign take          = bus.ins_valid && bus.ins_ready;
`else
    // A jr in EX never coexists with a lw in EX, but flush still wins.
    logic flush;
    assign flush         = jr_taken;
    assign bus.ins_ready = rst || flush || !hazard;
    assign take          = bus.ins_valid && bus.ins_ready && !flush;
`endif

    // ---------------- stage registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= EX_BUBBLE;
            mem_q       <= '0;
            wb_q        <= '0;
            vld_pipe    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q     <= take ? dec : EX_BUBBLE;
            mem_q    <= ex_q.mem;
            wb_q     <= mem_q.wb;
            vld_pipe <= {vld_pipe[1], take && dec_ok};
            if (bus.ins_valid && !bus.ins_ready && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.ex_valid    = vld_pipe[1];
    assign bus.ex_alu_sel  = ex_q.alu_sel;
    assign bus.ex_alu_code = ex_q.alu_code;
    assign bus.jr_taken    = jr_taken;
    assign bus.mem_valid   = vld_pipe[2];
    assign bus.mem_wen     = mem_q.mem_wen;
    assign bus.wb_reg_wen  = wb_q.reg_wen;
    assign bus.wb_dmem_alu = wb_q.dmem_alu;
    assign bus.wb_reg_addr = wb_q.reg_addr;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: decode table, hand-written multi-cycle sequences and
// randomized traffic checked every cycle against a behavioural model.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.ALU_CODE_W(5), .CNT_W(16)) bus();
    pipe_ctrl #(.ALU_CODE_W(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit v; int code; bit sel, wen, dmem, mwen; int addr; bit lw, jr;
    } mrec_t;

    mrec_t m_ex, m_mem, m_wb;
    int    m_cnt;
    bit    m_ready, m_jr;

    function automatic mrec_t m_bubble();
        mrec_t r;
        r = '{default: 0};
        r.code = 12;
        return r;
    endfunction

    function automatic void m_decode(input logic [31:0] w, output mrec_t r,
                                     output bit urs, output bit urt);
        int code;
        r = m_bubble(); urs = 0; urt = 0; code = -1;
        if (w == 0) return;
        if (w[31:26] == 0) begin
            case (w[5:0])
                6'h20: code = 0;  6'h21: code = 1;  6'h22: code = 2;
                6'h23: code = 3;  6'h24: code = 4;  6'h25: code = 5;
                6'h27: code = 6;  6'h2A: code = 7;  6'h00: code = 8;
                6'h02: code = 9;  6'h03: code = 10; 6'h08: code = 11;
                default: code = -1;
            endcase
            if (code < 0) return;
            r.v = 1; r.code = code; r.addr = w[15:11];
            r.wen = (code != 11); r.jr = (code == 11);
            urs = !(code inside {8, 9, 10}); urt = (code != 11);
        end else begin
            case (w[31:26])
                6'h0C: code = 13; 6'h0D: code = 14; 6'h0A: code = 15;
                6'h08: code = 16; 6'h09: code = 17; 6'h0F: code = 20;
                6'h23: code = 18; 6'h2B: code = 19;
                default: code = -1;
            endcase
            if (code < 0) return;
            r.v = 1; r.code = code; r.sel = 1; r.addr = w[20:16];
            r.wen = (code != 19); r.dmem = (code == 18); r.mwen = (code == 19);
            r.lw = (code == 18);
            urs = (code != 20); urt = (code == 19);
        end
        if (r.addr == 0) r.wen = 0;
    endfunction

    task automatic check_all();
        chk("ins_ready",   bus.ins_ready,   m_ready);
        chk("jr_taken",    bus.jr_taken,    m_jr);
        chk("ex_valid",    bus.ex_valid,    m_ex.v);
        chk("ex_alu_sel",  bus.ex_alu_sel,  m_ex.sel);
        chk("ex_alu_code", bus.ex_alu_code, m_ex.code);
        chk("mem_valid",   bus.mem_valid,   m_mem.v);
        chk("mem_wen",     bus.mem_wen,     m_mem.mwen);
        chk("wb_reg_wen",  bus.wb_reg_wen,  m_wb.wen);
        chk("wb_dmem_alu", bus.wb_dmem_alu, m_wb.dmem);
        chk("wb_reg_addr", bus.wb_reg_addr, m_wb.addr);
        chk("stall_cnt",   bus.stall_cnt,   m_cnt);
    endtask

    // One clock cycle: drive at the falling edge, compare, then advance model.
    task automatic cyc(input bit v, input logic [31:0] w, input bit r);
        mrec_t d;
        bit urs, urt, hz, fl;
        @(negedge clk);
        bus.ins_valid = v; bus.ins = w; rst = r;
        #1;
        m_decode(w, d, urs, urt);
        hz = v && m_ex.v && m_ex.lw && m_ex.addr != 0 &&
             ((urs && w[25:21] == m_ex.addr) || (urt && w[20:16] == m_ex.addr));
        m_jr = m_ex.v && m_ex.jr;
`ifdef PIPE_CTRL_DELAY_SLOT_EN
        fl = 0;
`else
        fl = m_jr;
`endif
        m_ready = r || fl || !hz;
        check_all();
        if (r) begin
            m_ex = m_bubble(); m_mem = m_bubble(); m_wb = m_bubble(); m_cnt = 0;
        end else begin
            if (v && !m_ready && m_cnt != 65535) m_cnt++;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (v && m_ready && !fl) ? d : m_bubble();
        end
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [31:0] w; bit v; int code; bit sel, wen, dmem, mwen; int addr;
    } vec_t;
    vec_t tbl[$];

    logic [5:0] rfun [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                              6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h08};
    logic [5:0] iop  [8]  = '{6'h0C, 6'h0D, 6'h0A, 6'h08, 6'h09, 6'h0F,
                              6'h23, 6'h2B};

    function automatic logic [31:0] rnd_ins();
        int k;
        logic [4:0] rs, rt, rd;
        k  = $urandom_range(0, 19);
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        if (k < 10)       return {6'h00, rs, rt, rd, 5'($urandom), rfun[$urandom_range(0, 11)]};
        else if (k < 17)  return {iop[$urandom_range(0, 7)], rs, rt, 16'($urandom)};
        else if (k == 17) return 32'h0;
        else              return $urandom;
    endfunction

    initial begin
        logic [31:0] cur;
        bit curv, r;
        rst = 1'b1; bus.ins_valid = 1'b0; bus.ins = 32'h0;
        m_ex = m_bubble(); m_mem = m_bubble(); m_wb = m_bubble(); m_cnt = 0;

        //            word          v  code sel wen dmem mwen addr
        tbl.push_back('{32'h00221820, 1, 0,  0, 1, 0, 0, 3});
        tbl.push_back('{32'h00221821, 1, 1,  0, 1, 0, 0, 3});
        tbl.push_back('{32'h00221822, 1, 2,  0, 1, 0, 0, 3});
        tbl.push_back('{32'h00221823, 1, 3,  0, 1, 0, 0, 3});
        tbl.push_back('{32'h00221824, 1, 4,  0, 1, 0, 0, 3});
        tbl.push_back('{32'h00221825, 1, 5,  0, 1, 0, 0, 3});
        tbl.push_back('{32'h00221827, 1, 6,  0, 1, 0, 0, 3});
        tbl.push_back('{32'h0022182A, 1, 7,  0, 1, 0, 0, 3});
        tbl.push_back('{32'h00221800, 1, 8,  0, 1, 0, 0, 3});
        tbl.push_back('{32'h00221802, 1, 9,  0, 1, 0, 0, 3});
        tbl.push_back('{32'h00221803, 1, 10, 0, 1, 0, 0, 3});
        tbl.push_back('{32'h03E00008, 1, 11, 0, 0, 0, 0, 0});
        tbl.push_back('{32'h30220005, 1, 13, 1, 1, 0, 0, 2});
        tbl.push_back('{32'h34220005, 1, 14, 1, 1, 0, 0, 2});
        tbl.push_back('{32'h28220005, 1, 15, 1, 1, 0, 0, 2});
        tbl.push_back('{32'h20220005, 1, 16, 1, 1, 0, 0, 2});
        tbl.push_back('{32'h24220005, 1, 17, 1, 1, 0, 0, 2});
        tbl.push_back('{32'h3C020005, 1, 20, 1, 1, 0, 0, 2});
        tbl.push_back('{32'h8C220000, 1, 18, 1, 1, 1, 0, 2});
        tbl.push_back('{32'hAC220004, 1, 19, 1, 0, 0, 1, 2});
        tbl.push_back('{32'hFC000000, 0, 12, 0, 0, 0, 0, 0});
        tbl.push_back('{32'h00000000, 0, 12, 0, 0, 0, 0, 0});
        tbl.push_back('{32'h00221801, 0, 12, 0, 0, 0, 0, 0});
        tbl.push_back('{32'h00000820, 1, 0,  0, 1, 0, 0, 1});
        tbl.push_back('{32'h00220020, 1, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{32'h20200005, 1, 16, 1, 0, 0, 0, 0});

        // reset state
        cyc(0, 32'h0, 1);
        chk("rst_ready", bus.ins_ready, 1);
        cyc(0, 32'h0, 0);
        chk("rst_code", bus.ex_alu_code, 12);
        chk("rst_cnt",  bus.stall_cnt, 0);

        foreach (tbl[i]) begin
            cyc(1, tbl[i].w, 0);
            cyc(0, 32'h0, 0);
            chk($sformatf("t%0d_ex_valid", i), bus.ex_valid,    tbl[i].v);
            chk($sformatf("t%0d_ex_code", i),  bus.ex_alu_code, tbl[i].code);
            chk($sformatf("t%0d_ex_sel", i),   bus.ex_alu_sel,  tbl[i].sel);
            cyc(0, 32'h0, 0);
            chk($sformatf("t%0d_mem_wen", i),  bus.mem_wen,     tbl[i].mwen);
            chk($sformatf("t%0d_mem_vld", i),  bus.mem_valid,   tbl[i].v);
            cyc(0, 32'h0, 0);
            chk($sformatf("t%0d_wb_wen", i),   bus.wb_reg_wen,  tbl[i].wen);
            chk($sformatf("t%0d_wb_dmem", i),  bus.wb_dmem_alu, tbl[i].dmem);
            chk($sformatf("t%0d_wb_addr", i),  bus.wb_reg_addr, tbl[i].addr);
        end

        // load-use: lw $2 then add $3,$2,$2 held valid
        cyc(0, 32'h0, 1);
        cyc(1, 32'h8C220000, 0);
        cyc(1, 32'h00421820, 0);
        chk("lu_stall_ready", bus.ins_ready, 0);
        cyc(1, 32'h00421820, 0);
        chk("lu_resume_ready", bus.ins_ready, 1);
        chk("lu_bubble_code",  bus.ex_alu_code, 12);
        chk("lu_cnt",          bus.stall_cnt, 1);
        cyc(0, 32'h0, 0);
        chk("lu_add_ex", bus.ex_alu_code, 0);
        cyc(0, 32'h0, 0);
        cyc(0, 32'h0, 0);
        chk("lu_add_wen",  bus.wb_reg_wen, 1);
        chk("lu_add_addr", bus.wb_reg_addr, 3);

        // reset mid-operation: lw in MEM, jr in EX, stall_cnt already 1
        cyc(1, 32'h8C220000, 0);
        cyc(1, 32'h03E00008, 0);
        chk("rm_lw_ex", bus.ex_alu_code, 18);
        cyc(1, 32'h00221820, 1);
        chk("rm_pre_jr",  bus.jr_taken, 1);
        chk("rm_pre_mem", bus.mem_wen | bus.mem_valid, 1);
        chk("rm_pre_cnt", bus.stall_cnt, 1);
        cyc(0, 32'h0, 0);
        chk("rm_ex_valid",  bus.ex_valid, 0);
        chk("rm_mem_valid", bus.mem_valid, 0);
        chk("rm_mem_wen",   bus.mem_wen, 0);
        chk("rm_wb_wen",    bus.wb_reg_wen, 0);
        chk("rm_jr",        bus.jr_taken, 0);
        chk("rm_cnt",       bus.stall_cnt, 0);

        // jr $31 followed by add $3,$1,$2
        cyc(1, 32'h03E00008, 0);
        cyc(1, 32'h00221820, 0);
        chk("jr_taken", bus.jr_taken, 1);
        chk("jr_ready", bus.ins_ready, 1);
        cyc(0, 32'h0, 0);
        cyc(0, 32'h0, 0);
        cyc(0, 32'h0, 0);
`ifdef PIPE_CTRL_DELAY_SLOT_EN
        chk("jr_slot_wen",  bus.wb_reg_wen, 1);
        chk("jr_slot_addr", bus.wb_reg_addr, 3);
`else
        chk("jr_squash_wen", bus.wb_reg_wen, 0);
`endif

        // randomized traffic; IF/ID holds its word while stalled
        curv = 0; cur = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (!(curv && !m_ready)) begin
                curv = ($urandom_range(0, 3) != 0);
                cur  = rnd_ins();
            end
            r = ($urandom_range(0, 99) == 0);
            cyc(curv, cur, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
